pixel_frame_streamer: RTL

PIXEL_FRAME_STREAMER -- requirements
Module: pixel_frame_streamer

---
 rtl/pixel_frame_streamer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pixel_frame_streamer.sv
// Streams a WIDTH x HEIGHT frame from a synchronous frame memory into a valid/ready sink.
// A 2-entry skid FIFO plus a credit check on read issue keeps 1 pixel/cycle without overflow.
module pixel_frame_streamer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_ready,
    output logic              o_mem_ren,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_pixel,
    input  logic [15:0]       i_mem_depth,
    output logic [7:0]        o_pixel,
    output logic [15:0]       o_depth,
    output logic              o_valid,
    output logic              o_frame_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight_q;
    logic              inflight_first_q;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, wr_ptr_q;
    logic [7:0]        pix_q [2];
    logic [15:0]       dep_q [2];
    logic [1:0]        fs_q;

    logic xfer;
    logic push;
    logic credit_ok;
    logic issue;

    assign o_valid = (count_q != 2'd0);
    assign xfer    = o_valid && i_ready;
    assign push    = inflight_q;

    // entries + in_flight - xfer <= 1, rearranged to avoid underflow
    assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, xfer});
    assign issue     = (state_q == S_RUN) && credit_ok;

    assign o_mem_ren  = issue;
    assign o_mem_addr = issue ? rd_cnt_q : addr_q;

    assign count_d = count_q + {1'b0, push} - {1'b0, xfer};

    assign o_pixel       = pix_q[rd_ptr_q];
    assign o_depth       = dep_q[rd_ptr_q];
    assign o_frame_start = o_valid && fs_q[rd_ptr_q];
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_RUN;
                    rd_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (rd_cnt_q == LAST_ADDR) state_d = S_DRAIN;
                    else                       rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                // Look ahead at next occupancy so DONE lands right after the last transfer
                if ((count_d == 2'd0) && !inflight_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= S_IDLE;
            rd_cnt_q         <= '0;
            addr_q           <= '0;
            inflight_q       <= 1'b0;
            inflight_first_q <= 1'b0;
            count_q          <= 2'd0;
            rd_ptr_q         <= 1'b0;
            wr_ptr_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            rd_cnt_q         <= rd_cnt_d;
            inflight_q       <= issue;
            inflight_first_q <= issue && (rd_cnt_q == '0);
            count_q          <= count_d;
            if (issue) addr_q   <= rd_cnt_q;
            if (push)  wr_ptr_q <= ~wr_ptr_q;
            if (xfer)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                pix_q[gi] <= 8'd0;
                dep_q[gi] <= 16'd0;
                fs_q[gi]  <= 1'b0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
                pix_q[gi] <= i_mem_pixel;
                dep_q[gi] <= i_mem_depth;
                fs_q[gi]  <= inflight_first_q;
            end
        end
    end

endmodule
